// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state type, default bus widths and a small index helper
// used by the bus arbiter and its round-robin picker.
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    // Next slot after idx in a ring of n entries.
    function automatic int ring_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection. Returns whether any request
// is set and the index of the first requester at or after ptr, wrapping
// N-1 -> 0. ptr must be below N.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest slot back towards ptr so the closest requester wins last.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output and
        // temporary gets a default before any conditional so no latch is inferred.
        any    = |req;
        winner = ptr;
        sum    = '0;
        cand   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one slave-side bus between NUM_MASTERS masters using the
// breq/bgrant protocol. Round-robin grant, held until the owner drops breq.
// The owner's mode/addr/wdata/valid are muxed to the slave; ready is returned
// to the owner only and rdata is broadcast.
// Optional feature: define BUS_ARB_TIMEOUT_EN to force release of a grant held
// for TIMEOUT_CYCLES cycles, with a one-cycle timeout_err pulse.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_MASTERS-1:0]          m_breq,
    output logic [NUM_MASTERS-1:0]          m_bgrant,
    input  logic [NUM_MASTERS-1:0]          m_mode,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS-1:0]          m_valid,
    output logic [NUM_MASTERS-1:0]          m_ready,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            s_mode,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic                            s_valid,
    input  logic                            s_ready,
    input  logic [DATA_W-1:0]               s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]  owner_id,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             granted;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (m_breq),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign granted = (state == ARB_GRANTED);
    assign busy    = granted;
    assign m_rdata = s_rdata;
    assign m_ready = m_bgrant & {NUM_MASTERS{s_ready}};

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             force_release;
`endif

    // Next state: arbitrate while idle; while granted, watch the owner's request
    // and, when enabled, how long the grant has been held.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner_id;
        rr_ptr_nxt = rr_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_nxt  = '0;
        force_release = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt  = ARB_GRANTED;
                    owner_nxt  = pick_idx;
                    rr_ptr_nxt = IDX_W'(ring_next(int'(pick_idx), NUM_MASTERS));
                end
            end
            ARB_GRANTED: begin
`ifdef BUS_ARB_TIMEOUT_EN
                hold_cnt_nxt = hold_cnt + CNT_W'(1);
`endif
                if (!m_breq[owner_id]) begin
                    state_nxt = ARB_IDLE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = ARB_IDLE;
                    force_release = 1'b1;
                end
`endif
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            owner_id <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Grant hold counter and the registered one-cycle forced-release pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            hold_cnt    <= hold_cnt_nxt;
            timeout_err <= force_release;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Slave-side mux and grant decode; everything is quiet unless a grant is held.
    always_comb begin
        m_bgrant = '0;
        s_mode   = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_valid  = 1'b0;
        if (granted) begin
            m_bgrant[owner_id] = 1'b1;
            s_mode             = m_mode[owner_id];
            s_addr             = m_addr[owner_id * ADDR_W +: ADDR_W];
            s_wdata            = m_wdata[owner_id * DATA_W +: DATA_W];
            s_valid            = m_valid[owner_id];
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized masters. A request-level
// model predicts grant, release, reset and timeout events into a queue; a
// negedge monitor consumes them and checks every bus output each cycle.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int IW = $clog2(N);
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  m_breq, m_bgrant, m_mode, m_valid, m_ready;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata, s_wdata, s_rdata;
    logic [AW-1:0] s_addr;
    logic          s_mode, s_valid, s_ready;
    logic [IW-1:0] owner_id;
    logic          busy, timeout_err;

    bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_breq(m_breq), .m_bgrant(m_bgrant), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_valid(m_valid), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_mode(s_mode), .s_addr(s_addr), .s_wdata(s_wdata), .s_valid(s_valid),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .owner_id(owner_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {EV_GRANT, EV_RELEASE, EV_RESET, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        int       edge_no;
        ev_kind_t kind;
        int       who;
    } ev_t;

    ev_t evq[$];

    int mdl_owner = -1;     // master holding the bus, -1 when free
    int mdl_last  = N - 1;  // most recent winner; the search starts just after it
    int mdl_gedge = 0;      // edge at which the current grant was given

    function automatic ev_t mk_ev(input int e, input ev_kind_t k, input int w);
        ev_t ev;
        ev.edge_no = e;
        ev.kind    = k;
        ev.who     = w;
        return ev;
    endfunction

    // Apply the arbitration rules to the inputs that edge e will sample.
    task automatic model_edge(input int e);
        logic [N-1:0] b;
        if (!rst_n) begin
            mdl_owner = -1;
            mdl_last  = N - 1;
            evq.push_back(mk_ev(e, EV_RESET, 0));
        end else if (mdl_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mdl_last + k) % N;
                b   = m_breq >> idx;
                if (b[0]) begin
                    mdl_owner = idx;
                    mdl_last  = idx;
                    mdl_gedge = e;
                    evq.push_back(mk_ev(e, EV_GRANT, idx));
                    break;
                end
            end
        end else begin
            b = m_breq >> mdl_owner;
            if (!b[0]) begin
                evq.push_back(mk_ev(e, EV_RELEASE, mdl_owner));
                mdl_owner = -1;
            end else if (TO_ON && (e - mdl_gedge) == TO) begin
                evq.push_back(mk_ev(e, EV_RELEASE, mdl_owner));
                evq.push_back(mk_ev(e, EV_TIMEOUT, mdl_owner));
                mdl_owner = -1;
            end
        end
    endtask

    // ---------------- monitor ----------------
    int exp_owner = -1;
    int exp_last  = 0;

    always @(negedge clk) begin : mon
        ev_t          ev;
        bit           exp_terr;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] sel;
        if (cyc >= 1) begin
            exp_terr = 1'b0;
            while (evq.size() > 0 && evq[0].edge_no <= cyc) begin
                ev = evq.pop_front();
                case (ev.kind)
                    EV_GRANT:   begin exp_owner = ev.who; exp_last = ev.who; end
                    EV_RELEASE: exp_owner = -1;
                    EV_RESET:   begin exp_owner = -1; exp_last = 0; end
                    EV_TIMEOUT: exp_terr = 1'b1;
                    default:    ;
                endcase
            end
            exp_gnt = (exp_owner >= 0) ? (N'(1) << exp_owner) : '0;
            check("bgrant", 64'(m_bgrant), 64'(exp_gnt));
            check("busy", 64'(busy), 64'(exp_owner >= 0));
            check("owner_id", 64'(owner_id), 64'(exp_last));
            check("m_ready", 64'(m_ready), 64'(s_ready ? exp_gnt : '0));
            check("m_rdata", 64'(m_rdata), 64'(s_rdata));
            check("timeout_err", 64'(timeout_err), 64'(exp_terr));
            if (exp_owner >= 0) begin
                sel = m_mode >> exp_owner;
                check("s_mode", 64'(s_mode), 64'(sel[0]));
                sel = m_valid >> exp_owner;
                check("s_valid", 64'(s_valid), 64'(sel[0]));
                check("s_addr", 64'(s_addr), 64'(AW'(m_addr >> (exp_owner * AW))));
                check("s_wdata", 64'(s_wdata), 64'(DW'(m_wdata >> (exp_owner * DW))));
            end else begin
                check("s_idle", 64'({s_mode, s_valid, s_addr, s_wdata}), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        model_edge(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic mode, input logic valid,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m_mode[i]              = mode;
        m_valid[i]             = valid;
        m_addr[i*AW +: AW]     = addr;
        m_wdata[i*DW +: DW]    = wdata;
    endtask

    localparam logic [N-1:0] SEQ_BREQ [8] = '{3'b001, 3'b011, 3'b010, 3'b011,
                                              3'b001, 3'b011, 3'b010, 3'b011};
    localparam logic [N-1:0] SEQ_GNT  [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                                              3'b000, 3'b001, 3'b000, 3'b010};

    logic [DW-1:0] rd_latch0;
    int            held [N];
    int            hold_len [N];

    initial begin
        rst_n = 1'b0; m_breq = '0; m_mode = '0; m_valid = '0;
        m_addr = '0; m_wdata = '0; s_ready = 1'b0; s_rdata = '0;
        rd_latch0 = '0;
        repeat (3) tick();
        check("rst_bgrant", 64'(m_bgrant), 64'd0);
        check("rst_owner", 64'(owner_id), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request: grant one cycle later, address routed, ready returned.
        set_master(0, 1'b1, 1'b1, 16'h1234, 8'h5C);
        m_breq  = 3'b001;
        s_ready = 1'b1;
        tick();
        check("t1_bgrant", 64'(m_bgrant), 64'b001);
        check("t1_s_addr", 64'(s_addr), 64'h1234);
        check("t1_m_ready", 64'(m_ready), 64'b001);

        // Read by master 0: rdata broadcast, master 1 not ready.
        set_master(0, 1'b0, 1'b1, 16'h1234, 8'h00);
        s_rdata = 8'hA5;
        #1;
        if (m_ready[0] && !m_mode[0]) rd_latch0 = m_rdata;
        check("t3_m_rdata", 64'(m_rdata), 64'hA5);
        check("t3_latch0", 64'(rd_latch0), 64'hA5);
        check("t3_ready1", 64'(m_ready[1]), 64'd0);

        // Master 1 waits while master 0 holds; granted two cycles after breq[0] drops.
        m_breq = 3'b011;
        tick();
        check("t4_hold_a", 64'(m_bgrant), 64'b001);
        tick();
        check("t4_hold_b", 64'(m_bgrant), 64'b001);
        m_breq = 3'b010;
        tick();
        check("t4_dead", 64'(m_bgrant), 64'b000);
        tick();
        check("t4_grant1", 64'(m_bgrant), 64'b010);

        // Both keep requesting, each releasing once granted: grants alternate.
        for (int k = 0; k < 8; k++) begin
            m_breq = SEQ_BREQ[k];
            tick();
            check("t2_seq", 64'(m_bgrant), 64'(SEQ_GNT[k]));
        end

        // Reset while master 1 owns the bus with valid high.
        m_valid = '1;
        #1;
        check("t5_pre_valid", 64'(s_valid), 64'd1);
        check("t5_pre_owner", 64'(owner_id), 64'd1);
        rst_n = 1'b0;
        tick();
        check("t5_bgrant", 64'(m_bgrant), 64'd0);
        check("t5_s_valid", 64'(s_valid), 64'd0);
        check("t5_owner", 64'(owner_id), 64'd0);
        rst_n  = 1'b1;
        m_breq = '0;
        tick();
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        begin : t6
            int hold0;
            int terr_seen;
            bit got1;
            hold0 = 0; terr_seen = 0; got1 = 1'b0;
            s_ready = 1'b0;
            m_breq  = 3'b011;
            for (int k = 0; k < 30 && !got1; k++) begin
                tick();
                if (m_bgrant == 3'b001) hold0++;
                if (timeout_err) terr_seen++;
                if (m_bgrant == 3'b010) got1 = 1'b1;
            end
            check("t6_hold_cycles", 64'(hold0), 64'(TO));
            check("t6_pulses", 64'(terr_seen), 64'd1);
            check("t6_next_owner", 64'(got1), 64'd1);
            m_breq = '0;
            tick();
            tick();
        end
`endif

        // Randomized masters with occasional resets.
        for (int i = 0; i < N; i++) begin
            held[i] = 0;
            hold_len[i] = 1;
        end
        repeat (1500) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            s_ready = 1'($urandom_range(0, 1));
            s_rdata = DW'($urandom);
            for (int i = 0; i < N; i++) begin
                set_master(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           AW'($urandom), DW'($urandom));
                if (m_breq[i]) begin
                    if (m_bgrant[i]) begin
                        held[i]++;
                        if (held[i] >= hold_len[i]) m_breq[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    m_breq[i]   = 1'b1;
                    held[i]     = 0;
                    hold_len[i] = int'($urandom_range(1, 11));
                end
            end
            tick();
        end

        rst_n  = 1'b1;
        m_breq = '0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        check("queue_drained", 64'(evq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
